// File: rtl/plic_claim_arbiter.sv
// Wishbone-attached interrupt gateway plus claim/complete arbiter: latches level sources,
// picks the highest-priority eligible source and blocks re-delivery while it is in flight.
module plic_claim_arbiter #(
  parameter int unsigned NSRC   = 8,
  parameter int unsigned PRIO_W = 3,
  parameter logic [31:0] BASE   = 32'h0C00_0000,
  parameter int unsigned aw     = 32,
  parameter int unsigned dw     = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  output logic [dw-1:0]   wb_dat_o,
  input  logic [3:0]      wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  input  logic [NSRC-1:0] irq_src_i,
  output logic            ext_irq_o,
  output logic [7:0]      best_id_o
);

  localparam logic [aw-1:0] OffPend  = aw'(32'h0000_1000);
  localparam logic [aw-1:0] OffEn    = aw'(32'h0000_2000);
  localparam logic [aw-1:0] OffThr   = aw'(32'h0020_0000);
  localparam logic [aw-1:0] OffClaim = aw'(32'h0020_0004);

  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [NSRC-1:0]   en_q, en_d, pend_q, pend_d, infl_q, infl_d;
  logic              ack_q, ext_q;
  logic [dw-1:0]     dat_q, dat_d, rdata;
  logic [7:0]        best_q, win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [aw-1:0]     off;
  logic [9:0]        widx;
  logic              in_prio, acc_edge;
  logic              unused_bits;

  assign off         = wb_adr_i - aw'(BASE);
  assign widx        = off[11:2];
  assign in_prio     = (off < OffPend) && (off[1:0] == 2'b00);
  // Side effects happen only on the edge that raises ack, so each access acts once.
  assign acc_edge    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign unused_bits = ^{wb_sel_i, wb_dat_i, irq_src_i[0]};

  // Strict '>' keeps the lowest ID on priority ties; eligible implies priority > 0.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 1; i < NSRC; i++) begin
      if (pend_q[i] && en_q[i] && (prio_q[i] > thr_q) && (prio_q[i] > win_prio)) begin
        win_id   = 8'(i);
        win_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (in_prio) begin
      for (int i = 1; i < NSRC; i++) begin
        if (widx == 10'(i)) rdata[PRIO_W-1:0] = prio_q[i];
      end
    end else if (off == OffPend) begin
      rdata[NSRC-1:0] = pend_q;
    end else if (off == OffEn) begin
      rdata[NSRC-1:0] = en_q;
    end else if (off == OffThr) begin
      rdata[PRIO_W-1:0] = thr_q;
    end else if (off == OffClaim) begin
      rdata[7:0] = best_q;
    end
  end

  always_comb begin
    prio_d = prio_q;
    thr_d  = thr_q;
    en_d   = en_q;
    infl_d = infl_q;
    dat_d  = dat_q;
    pend_d = pend_q | (irq_src_i & ~pend_q & ~infl_q);
    pend_d[0] = 1'b0;
    if (acc_edge) begin
      if (wb_we_i) begin
        if (in_prio) begin
          for (int i = 1; i < NSRC; i++) begin
            if (widx == 10'(i)) prio_d[i] = wb_dat_i[PRIO_W-1:0];
          end
        end else if (off == OffEn) begin
          en_d = {wb_dat_i[NSRC-1:1], 1'b0};
        end else if (off == OffThr) begin
          thr_d = wb_dat_i[PRIO_W-1:0];
        end else if (off == OffClaim) begin
          for (int i = 1; i < NSRC; i++) begin
            if (wb_dat_i[7:0] == 8'(i)) infl_d[i] = 1'b0;
          end
        end
      end else begin
        dat_d = rdata;
        // Claim overrides a same-edge gateway set of the claimed source.
        if (off == OffClaim) begin
          for (int i = 1; i < NSRC; i++) begin
            if (best_q == 8'(i)) begin
              pend_d[i] = 1'b0;
              infl_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
      thr_q  <= '0;
      en_q   <= '0;
      pend_q <= '0;
      infl_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      best_q <= '0;
      ext_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      thr_q  <= thr_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      infl_q <= infl_d;
      ack_q  <= wb_cyc_i & wb_stb_i & ~ack_q;
      dat_q  <= dat_d;
      best_q <= win_id;
      ext_q  <= (win_id != 8'd0);
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign best_id_o = best_q;
  assign ext_irq_o = ext_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Directed bench for plic_claim_arbiter: Wishbone accesses with hand-computed expectations.
module tb_plic_claim_arbiter;

  localparam logic [31:0] Base     = 32'h0C00_0000;
  localparam logic [31:0] OffPend  = 32'h0000_1000;
  localparam logic [31:0] OffEn    = 32'h0000_2000;
  localparam logic [31:0] OffThr   = 32'h0020_0000;
  localparam logic [31:0] OffClaim = 32'h0020_0004;

  logic        clk, rst;
  logic [31:0] adr, wdat, rdat_o;
  logic [3:0]  sel;
  logic        we, stb, cyc, ack;
  logic [7:0]  src;
  logic        ext;
  logic [7:0]  best;
  logic [31:0] rv;

  int n_cmp = 0;
  int n_err = 0;

  plic_claim_arbiter #(
    .NSRC(8), .PRIO_W(3), .BASE(Base), .aw(32), .dw(32)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat_o),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (ack),
    .irq_src_i(src),
    .ext_irq_o(ext),
    .best_id_o(best)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; returns #1 after the ack edge with stb dropped.
  task automatic wb_xfer(input logic w, input logic [31:0] off, input logic [31:0] d,
                         output logic [31:0] r);
    logic got;
    got  = 1'b0;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = Base + off;
    wdat = d;
    for (int c = 0; c < 4 && !got; c++) begin
      @(posedge clk);
      #1;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    r   = rdat_o;
    check_eq("ack", {31'b0, got}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, off, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, off, 32'd0, r);
    check_eq(tag, r, exp);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = 4'hF; src = 8'hFF;

    // Reset with all sources high
    tick(3);
    check_eq("rst_ext", {31'b0, ext}, 32'd0);
    check_eq("rst_best", {24'b0, best}, 32'd0);
    check_eq("rst_ack", {31'b0, ack}, 32'd0);
    rst = 1'b0;
    src = 8'h00;
    tick(1);
    rd_chk("rst_prio1", 32'h4, 32'd0);
    rd_chk("rst_en", OffEn, 32'd0);
    rd_chk("rst_pend", OffPend, 32'd0);
    rd_chk("rst_thr", OffThr, 32'd0);
    rd_chk("rst_claim", OffClaim, 32'd0);
    check_eq("rst_ext2", {31'b0, ext}, 32'd0);

    // Single UART interrupt
    wr(32'h4, 32'd3);
    wr(OffEn, 32'h2);
    wr(OffThr, 32'd1);
    src[1] = 1'b1;
    tick(1);
    check_eq("uart_ext_e1", {31'b0, ext}, 32'd0);
    tick(1);
    check_eq("uart_ext_e2", {31'b0, ext}, 32'd1);
    check_eq("uart_best", {24'b0, best}, 32'd1);
    rd_chk("uart_pend", OffPend, 32'h2);
    rd_chk("uart_claim", OffClaim, 32'd1);
    tick(1);
    check_eq("uart_ext_drop", {31'b0, ext}, 32'd0);
    rd_chk("uart_pend_infl", OffPend, 32'h0);
    wr(OffClaim, 32'd1);
    tick(2);
    check_eq("uart_ext_rearm", {31'b0, ext}, 32'd1);
    check_eq("uart_best_rearm", {24'b0, best}, 32'd1);
    rd_chk("uart_pend_rearm", OffPend, 32'h2);
    src[1] = 1'b0;
    rd_chk("uart_claim2", OffClaim, 32'd1);
    wr(OffClaim, 32'd1);
    tick(2);
    check_eq("uart_ext_idle", {31'b0, ext}, 32'd0);

    // Arbitration order
    wr(32'h4, 32'd2);
    wr(32'h8, 32'd5);
    wr(OffEn, 32'h6);
    src[2:1] = 2'b11;
    tick(2);
    rd_chk("arb_claim_hi", OffClaim, 32'd2);
    tick(1);
    rd_chk("arb_claim_lo", OffClaim, 32'd1);
    wr(32'h4, 32'd4);
    wr(32'h8, 32'd4);
    wr(OffClaim, 32'd2);
    wr(OffClaim, 32'd1);
    tick(2);
    check_eq("arb_tie_best", {24'b0, best}, 32'd1);
    rd_chk("arb_tie_claim", OffClaim, 32'd1);
    src[2:1] = 2'b00;
    wr(OffClaim, 32'd1);
    tick(1);
    rd_chk("arb_claim_rest", OffClaim, 32'd2);
    wr(OffClaim, 32'd2);
    tick(2);
    check_eq("arb_ext_idle", {31'b0, ext}, 32'd0);

    // Threshold boundary
    wr(OffEn, 32'h4);
    wr(32'h8, 32'd3);
    wr(OffThr, 32'd3);
    src[2] = 1'b1;
    tick(3);
    check_eq("thr_eq_ext", {31'b0, ext}, 32'd0);
    check_eq("thr_eq_best", {24'b0, best}, 32'd0);
    wr(OffThr, 32'd2);
    tick(1);
    check_eq("thr_lo_ext", {31'b0, ext}, 32'd1);
    check_eq("thr_lo_best", {24'b0, best}, 32'd2);

    // Invalid completes while source 2 is in flight with its line held high
    rd_chk("inv_claim2", OffClaim, 32'd2);
    wr(OffClaim, 32'd5);
    wr(OffClaim, 32'h3F);
    tick(2);
    rd_chk("inv_pend", OffPend, 32'h0);
    check_eq("inv_ext", {31'b0, ext}, 32'd0);
    wr(OffClaim, 32'd2);
    tick(2);
    check_eq("inv_ext_rearm", {31'b0, ext}, 32'd1);
    rd_chk("inv_pend_rearm", OffPend, 32'h4);
    src[2] = 1'b0;
    rd_chk("inv_claim3", OffClaim, 32'd2);
    wr(OffClaim, 32'd2);
    tick(2);
    rd_chk("inv_claim_none", OffClaim, 32'd0);
    check_eq("inv_ext_none", {31'b0, ext}, 32'd0);
    rd_chk("inv_pend_none", OffPend, 32'h0);

    // Unmapped offsets and field truncation
    rd_chk("unmap_3000", 32'h3000, 32'd0);
    rd_chk("prio_id8", 32'h20, 32'd0);
    wr(32'h0, 32'd7);
    rd_chk("prio0_ro", 32'h0, 32'd0);
    wr(32'hC, 32'hFF);
    rd_chk("prio3_trunc", 32'hC, 32'd7);
    wr(OffEn, 32'hFFFF_FFFF);
    rd_chk("en_trunc", OffEn, 32'hFE);
    wr(OffThr, 32'hFF);
    rd_chk("thr_trunc", OffThr, 32'd7);

    // Mid-access reset
    wr(OffThr, 32'd0);
    wr(OffEn, 32'h2);
    wr(32'h4, 32'd3);
    src[1] = 1'b1;
    tick(2);
    check_eq("mid_ext_pre", {31'b0, ext}, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = Base + OffThr; wdat = 32'd5;
    rst = 1'b1;
    tick(1);
    check_eq("mid_ack", {31'b0, ack}, 32'd0);
    check_eq("mid_ext", {31'b0, ext}, 32'd0);
    check_eq("mid_best", {24'b0, best}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    src = 8'h00;
    rst = 1'b0;
    tick(1);
    check_eq("mid_ack2", {31'b0, ack}, 32'd0);
    rd_chk("mid_prio1", 32'h4, 32'd0);
    rd_chk("mid_en", OffEn, 32'd0);
    rd_chk("mid_thr", OffThr, 32'd0);
    rd_chk("mid_pend", OffPend, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
